// File: rtl/uart_rx_deserializer_if.sv
// Bus between the UART receiver and its byte consumer.
// The master modport is the receiver: it takes the serial line in and
// produces the received byte, its strobes and the busy flag.
interface uart_rx_deserializer_if;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx_in,
    output data_out,
    output data_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx_in,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes the serial line, finds the start bit,
// samples eight data bits LSB first at mid-bit and checks the stop bit.
// data_out holds the last good byte; data_valid/frame_err are 1-cycle pulses.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_deserializer_if.master bus
);

  // Counter must hold CLKS_PER_BIT-1; CLKS_PER_BIT >= 4 keeps this at least 2 bits.
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] HalfTc = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullTc = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_t;

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            err_q;
  logic            busy_q;

  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;
  logic fall;

  // Two-flop synchronizer plus a delay flop for edge detection; all idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx_in;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // High-to-low transition of the synchronized line.
  always_comb begin
    fall = rx_prev_q & ~rx_sync_q;
  end

  // Receive FSM with its counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Edge detection is only armed here; edges inside a frame are ignored.
          if (fall) begin
            state_q <= StStart;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        StStart: begin
          // Re-check the line at the middle of the start bit to reject glitches.
          if (cnt_q == HalfTc) begin
            cnt_q <= '0;
            if (!rx_sync_q) begin
              state_q   <= StData;
              bit_idx_q <= 3'd0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StData: begin
          // One full bit period from the previous mid-bit lands on the next mid-bit.
          if (cnt_q == FullTc) begin
            cnt_q     <= '0;
            shreg_q   <= {rx_sync_q, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StStop: begin
          if (cnt_q == FullTc) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (rx_sync_q) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.data_out   = data_q;
    bus.data_valid = valid_q;
    bus.frame_err  = err_q;
    bus.busy       = busy_q;
  end

endmodule
